// File: rtl/simplez_io.sv
// simplez_io: memory-mapped LED register and 8N1 UART transmitter for the Simplez CPU.
// Ports: clk (state updates on falling edge), rstn (sync active-low reset), addr/wr/data_in (CPU write side),
// data_out (registered read data, 1-clock latency), leds (LED register), tx (serial line, idle high).
module simplez_io #(
  parameter int         BAUD_DIV  = 104,
  parameter logic [8:0] ADDR_BASE = 9'o100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  addr,
  input  logic        wr,
  input  logic [11:0] data_in,
  output logic [11:0] data_out,
  output logic [3:0]  leds,
  output logic        tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [11:0] LAST = 12'(BAUD_DIV - 1);
  state_t      state_q, state_d;
  logic [11:0] baud_q, baud_d, dout_q, dout_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  leds_q, leds_d;
  logic        ovr_q, ovr_d, tx_q, tx_d;
  logic        sel_led, sel_tx, sel_st, unused_hi;
  assign sel_led   = addr == ADDR_BASE;
  assign sel_tx    = addr == ADDR_BASE + 9'd1;
  assign sel_st    = addr == ADDR_BASE + 9'd2;
  assign unused_hi = ^data_in[11:8];
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 12'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    leds_d  = wr && sel_led ? {1'b1, data_in[2:0]} : leds_q;
    ovr_d   = wr && sel_tx && state_q != IDLE ? 1'b1 : wr && sel_st && data_in[1] ? 1'b0 : ovr_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (wr && sel_tx) begin
          state_d = START;
          sh_d    = data_in[7:0];
        end
      end
      START: if (baud_q == LAST) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end
      DATA: if (baud_q == LAST) begin
        baud_d  = '0;
        sh_d    = sh_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (baud_q == LAST) begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
    // tx is registered from the next state so it changes on the same edge as the FSM
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
    dout_d = sel_led ? {8'b0, leds_q} : sel_st ? {10'b0, ovr_q, state_q == IDLE} : 12'b0;
  end
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      leds_q  <= '0;
      ovr_q   <= 1'b0;
      tx_q    <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      leds_q  <= leds_d;
      ovr_q   <= ovr_d;
      tx_q    <= tx_d;
      dout_q  <= dout_d;
    end
  end
  assign data_out = dout_q;
  assign leds     = leds_q;
  assign tx       = tx_q;
endmodule

// File: tb/tb_simplez_io.sv
// tb_simplez_io: directed self-checking bench for simplez_io with BAUD_DIV=4.
module tb_simplez_io;
  localparam logic [8:0] A_LED = 9'o100, A_TX = 9'o101, A_ST = 9'o102, A_UN = 9'o103;
  logic        clk = 1'b0, rstn = 1'b0, wr = 1'b0, tx;
  logic [8:0]  addr = '0;
  logic [11:0] data_in = '0, data_out;
  logic [3:0]  leds;
  int          checks = 0, errors = 0;
  simplez_io #(.BAUD_DIV(4), .ADDR_BASE(9'o100)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .wr(wr), .data_in(data_in),
    .data_out(data_out), .leds(leds), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [8:0] a, input logic w, input logic [11:0] d);
    addr = a;
    wr = w;
    data_in = d;
  endtask
  // Called just after the accepting edge; leaves off just after the STOP-completion edge.
  // inj > 0 presents a TXDATA write of d2 at accepting-edge + inj.
  task automatic frame(input string tag, input logic [7:0] b, input int inj, input logic [7:0] d2);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), {11'b0, tx}, {11'b0, f[i/4]});
      if (i > 0 && addr == A_ST) chk($sformatf("%s_busy%0d", tag, i), {11'b0, data_out[0]}, 12'd0);
      if (i == inj - 1) drive(A_TX, 1'b1, {4'b0, d2});
      else drive(A_ST, 1'b0, 12'd0);
      tick;
    end
  endtask
  initial begin
    drive(A_LED, 1'b1, 12'o0007);
    tick;
    tick;
    chk("rst_leds", {8'b0, leds}, 12'd0);
    chk("rst_tx", {11'b0, tx}, 12'd1);
    chk("rst_dout", data_out, 12'd0);
    rstn = 1'b1;
    drive(A_ST, 1'b0, 12'd0);
    tick;
    chk("rst_status", data_out, 12'o0001);
    drive(A_LED, 1'b1, 12'o7775);
    tick;
    chk("led_wr", {8'b0, leds}, 12'b1101);
    drive(A_LED, 1'b0, 12'd0);
    tick;
    chk("led_rd", data_out, 12'o0015);
    drive(A_UN, 1'b1, 12'o0000);
    tick;
    chk("unmapped_wr", {8'b0, leds}, 12'b1101);
    chk("unmapped_rd", data_out, 12'd0);
    drive(A_TX, 1'b0, 12'd0);
    tick;
    chk("txdata_rd", data_out, 12'd0);
    drive(A_TX, 1'b1, 12'h0A5);
    tick;
    frame("a5", 8'hA5, 0, 8'h00);
    chk("a5_idle_tx", {11'b0, tx}, 12'd1);
    tick;
    chk("a5_ready", data_out, 12'o0001);
    drive(A_TX, 1'b1, 12'h041);
    tick;
    frame("ovr", 8'h41, 10, 8'h42);
    tick;
    chk("ovr_after", data_out, 12'o0003);
    drive(A_ST, 1'b1, 12'o0002);
    tick;
    drive(A_ST, 1'b0, 12'd0);
    tick;
    chk("ovr_clear", data_out, 12'o0001);
    drive(A_TX, 1'b1, 12'h03C);
    tick;
    frame("bnd1", 8'h3C, 40, 8'h55);
    chk("bnd_stop_tx", {11'b0, tx}, 12'd1);
    drive(A_TX, 1'b1, 12'h096);
    tick;
    frame("bnd2", 8'h96, 0, 8'h00);
    tick;
    chk("bnd_ovr", data_out, 12'o0003);
    drive(A_ST, 1'b1, 12'o0002);
    tick;
    drive(A_TX, 1'b1, 12'h000);
    tick;
    drive(A_ST, 1'b0, 12'd0);
    for (int i = 0; i < 14; i++) tick;
    chk("mid_tx_low", {11'b0, tx}, 12'd0);
    rstn = 1'b0;
    tick;
    chk("mid_rst_tx", {11'b0, tx}, 12'd1);
    rstn = 1'b1;
    tick;
    chk("mid_ready", data_out, 12'o0001);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("mid_idle%0d", i), {11'b0, tx}, 12'd1);
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
